// File: rtl/ipif_access_arbiter_if.sv
// Requester-side and register-bank-side signals of the IPIF access arbiter.
// The master modport belongs to the arbiter; the slave modport to requesters and bank.
interface ipif_access_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int N_REG = 2,
    parameter int DW    = 32
);
    localparam int AW = (N_REG > 1) ? $clog2(N_REG) : 1;

    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_write;
    logic [N_REQ*AW-1:0] req_addr;
    logic [N_REQ*DW-1:0] req_wdata;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [DW-1:0]       rsp_rdata;
    logic                rsp_err;
    logic [N_REG-1:0]    RdCE;
    logic [N_REG-1:0]    WrCE;
    logic [DW-1:0]       bank_wdata;
    logic [DW-1:0]       bank_rdata;
    logic                bank_ack;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bank_rdata, bank_ack,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, RdCE, WrCE, bank_wdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bank_rdata, bank_ack,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, RdCE, WrCE, bank_wdata
    );
endinterface

// File: rtl/ipif_access_arbiter.sv
// Round-robin arbiter sharing one IPIF register-bank port among N_REQ requesters:
// one strobe per grant, wait for ack or timeout, then a response pulse to the winner.
module ipif_access_arbiter #(
    parameter int N_REQ              = 4,
    parameter int N_REG              = 2,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT            = 255
) (
    input logic                   IP_clk,
    input logic                   IP_rst,
    ipif_access_arbiter_if.master bus
);
    localparam int AW = (N_REG > 1) ? $clog2(N_REG) : 1;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int GW = $clog2(N_REQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [GW-1:0] r_grant;
    logic [GW-1:0] r_rr_ptr;
    logic          r_write;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic [15:0]   r_timeout_cnt;

    logic [GW-1:0]    w_winner;
    logic [GW-1:0]    w_cand;
    logic             w_found;
    logic             w_legal;
    logic [15:0]      w_cnt_inc;
    logic             w_timeout;
    logic [N_REG-1:0] w_addr_oh;
    logic [N_REQ-1:0] w_grant_oh;
    logic [GW-1:0]    w_rr_nxt;

    assign w_legal    = (32'(r_addr) < 32'(N_REG));
    assign w_addr_oh  = N_REG'(1'b1) << r_addr;
    assign w_grant_oh = N_REQ'(1'b1) << r_grant;
    assign w_cnt_inc  = (r_timeout_cnt == 16'hFFFF) ? r_timeout_cnt : r_timeout_cnt + 16'd1;
    assign w_timeout  = (w_cnt_inc >= 16'(TIMEOUT));
    assign w_rr_nxt   = (32'(r_grant) == 32'(N_REQ - 1)) ? {GW{1'b0}} : r_grant + GW'(1);

    // Rotating-priority search: first valid requester at or above rr_ptr.
    always_comb begin
        w_found  = 1'b0;
        w_winner = {GW{1'b0}};
        w_cand   = {GW{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = GW'((32'(r_rr_ptr) + 32'(k)) % 32'(N_REQ));
            if (!w_found && bus.req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end else begin
                w_found  = w_found;
            end
        end
    end

    // Next-state decision.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (|bus.req_valid) w_state_nxt = S_ISSUE;
                else                w_state_nxt = S_IDLE;
            end
            S_ISSUE: begin
                if (!w_legal || bus.bank_ack) w_state_nxt = S_RESP;
                else                          w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (bus.bank_ack || w_timeout) w_state_nxt = S_RESP;
                else                           w_state_nxt = S_WAIT;
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register plus the request latch, capture and rotation pointer.
    always_ff @(posedge IP_clk) begin
        if (IP_rst) begin
            r_state       <= S_IDLE;
            r_grant       <= {GW{1'b0}};
            r_rr_ptr      <= {GW{1'b0}};
            r_write       <= 1'b0;
            r_addr        <= {AW{1'b0}};
            r_wdata       <= {DW{1'b0}};
            r_rdata       <= {DW{1'b0}};
            r_err         <= 1'b0;
            r_timeout_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (|bus.req_valid) begin
                        r_grant <= w_winner;
                        r_write <= bus.req_write[w_winner];
                        r_addr  <= bus.req_addr[32'(w_winner)*AW +: AW];
                        r_wdata <= bus.req_wdata[32'(w_winner)*DW +: DW];
                        r_rdata <= {DW{1'b0}};
                        r_err   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    r_timeout_cnt <= 16'd0;
                    if (!w_legal) begin
                        r_err   <= 1'b1;
                        r_rdata <= {DW{1'b0}};
                    end else if (bus.bank_ack) begin
                        r_err   <= 1'b0;
                        r_rdata <= bus.bank_rdata;
                    end
                end
                S_WAIT: begin
                    r_timeout_cnt <= w_cnt_inc;
                    // Ack wins over a timeout landing in the same cycle.
                    if (bus.bank_ack) begin
                        r_err   <= 1'b0;
                        r_rdata <= bus.bank_rdata;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= {DW{1'b0}};
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= w_rr_nxt;
                end
                default: begin
                    r_rr_ptr <= r_rr_ptr;
                end
            endcase
        end
    end

    assign bus.req_ready  = (r_state == S_ISSUE) ? w_grant_oh : {N_REQ{1'b0}};
    assign bus.RdCE       = (r_state == S_ISSUE && w_legal && !r_write) ? w_addr_oh : {N_REG{1'b0}};
    assign bus.WrCE       = (r_state == S_ISSUE && w_legal && r_write) ? w_addr_oh : {N_REG{1'b0}};
    assign bus.bank_wdata = (r_state == S_ISSUE && w_legal && r_write) ? r_wdata : {DW{1'b0}};
    assign bus.rsp_valid  = (r_state == S_RESP) ? w_grant_oh : {N_REQ{1'b0}};
    assign bus.rsp_rdata  = (r_state == S_RESP) ? r_rdata : {DW{1'b0}};
    assign bus.rsp_err    = (r_state == S_RESP) && r_err;
endmodule

// File: tb/tb_ipif_access_arbiter.sv
// Randomised bench for ipif_access_arbiter against a transaction-level timeline model.
module tb_ipif_access_arbiter;
    localparam int NRQ = 4;
    localparam int NRG = 3;
    localparam int DW  = 32;
    localparam int TO  = 4;
    localparam int AW  = 2;
    localparam int NEVER = 99;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ipif_access_arbiter_if #(.N_REQ(NRQ), .N_REG(NRG), .DW(DW)) bus ();

    ipif_access_arbiter #(
        .N_REQ(NRQ), .N_REG(NRG), .C_S_AXI_DATA_WIDTH(DW), .TIMEOUT(TO)
    ) dut (
        .IP_clk(clk),
        .IP_rst(rst),
        .bus   (bus)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    int            rr = 0;
    bit            rv [NRQ];
    bit            rw [NRQ];
    logic [AW-1:0] ra [NRQ];
    logic [DW-1:0] rd [NRQ];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic new_req(input int i);
        rv[i] = 1'b1;
        rw[i] = 1'($urandom_range(0, 1));
        ra[i] = AW'($urandom_range(0, 3));
        rd[i] = $urandom;
    endtask

    task automatic set_req(input int i, input bit w, input int a, input logic [31:0] d);
        rv[i] = 1'b1;
        rw[i] = w;
        ra[i] = AW'(a);
        rd[i] = d;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NRQ; i++) begin
            bus.req_valid[i]            = rv[i];
            bus.req_write[i]            = rw[i];
            bus.req_addr[i*AW +: AW]    = ra[i];
            bus.req_wdata[i*DW +: DW]   = rd[i];
        end
    endtask

    task automatic random_arrivals();
        for (int i = 0; i < NRQ; i++) begin
            if (!rv[i] && $urandom_range(0, 3) == 0) new_req(i);
        end
    endtask

    task automatic check_all_zero();
        check_eq("zero_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("zero_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("zero_RdCE", 32'(bus.RdCE), 32'd0);
        check_eq("zero_WrCE", 32'(bus.WrCE), 32'd0);
        check_eq("zero_rsp_rdata", bus.rsp_rdata, 32'd0);
        check_eq("zero_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("zero_bank_wdata", bus.bank_wdata, 32'd0);
    endtask

    // One arbitration round starting in an IDLE cycle. k: ack delay after the strobe
    // (k > TO means never). spur: extra acks in IDLE/RESP that must be ignored.
    task automatic run_txn(input int k, input logic [31:0] ack_dat, input bit spur,
                           input bit refill, input bit arrive, input int stop_at);
        int               g;
        int               t_resp;
        bit               legal;
        bit               acked;
        bit               wr;
        logic [DW-1:0]    wd;
        logic [DW-1:0]    exp_rdata;
        logic [NRQ-1:0]   g_oh;
        logic [NRG-1:0]   ce;
        g = -1;
        for (int j = 0; j < NRQ; j++) begin
            automatic int c = (rr + j) % NRQ;
            if (g < 0 && rv[c]) g = c;
        end
        if (g < 0) begin
            bus.bank_ack   = spur;
            bus.bank_rdata = $urandom;
            drive_reqs();
            @(negedge clk);
            check_eq("idle_req_ready", 32'(bus.req_ready), 32'd0);
            check_eq("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check_eq("idle_RdCE", 32'(bus.RdCE), 32'd0);
            check_eq("idle_WrCE", 32'(bus.WrCE), 32'd0);
            @(posedge clk); #1;
            if (arrive) random_arrivals();
            return;
        end
        legal     = (int'(ra[g]) < NRG);
        acked     = legal && (k <= TO);
        t_resp    = !legal ? 2 : (acked ? 2 + k : 2 + TO);
        wr        = rw[g];
        wd        = rd[g];
        exp_rdata = acked ? ack_dat : 32'd0;
        g_oh      = NRQ'(1) << g;
        ce        = legal ? (NRG'(1) << ra[g]) : NRG'(0);
        for (int t = 0; t <= t_resp && t < stop_at; t++) begin
            bus.bank_ack   = (acked && t == 1 + k) || (spur && (t == 0 || t == t_resp));
            bus.bank_rdata = (acked && t == 1 + k) ? ack_dat : $urandom;
            if (t == 2) begin
                rv[g] = 1'b0;
                if (refill) new_req(g);
            end
            if (arrive && t >= 1) random_arrivals();
            drive_reqs();
            @(negedge clk);
            check_eq("req_ready", 32'(bus.req_ready), (t == 1) ? 32'(g_oh) : 32'd0);
            check_eq("RdCE", 32'(bus.RdCE), (t == 1 && !wr) ? 32'(ce) : 32'd0);
            check_eq("WrCE", 32'(bus.WrCE), (t == 1 && wr) ? 32'(ce) : 32'd0);
            if (t == 1 && legal && wr) check_eq("bank_wdata", bus.bank_wdata, wd);
            check_eq("rsp_valid", 32'(bus.rsp_valid), (t == t_resp) ? 32'(g_oh) : 32'd0);
            if (t == t_resp) begin
                check_eq("rsp_rdata", bus.rsp_rdata, exp_rdata);
                check_eq("rsp_err", 32'(bus.rsp_err), acked ? 32'd0 : 32'd1);
            end
            @(posedge clk); #1;
        end
        if (stop_at > t_resp) rr = (g + 1) % NRQ;
    endtask

    initial begin
        rst            = 1'b1;
        bus.bank_ack   = 1'b1;
        bus.bank_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < NRQ; i++) new_req(i);
        drive_reqs();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero();
        @(posedge clk); #1;
        rst          = 1'b0;
        bus.bank_ack = 1'b0;
        for (int i = 0; i < NRQ; i++) rv[i] = 1'b0;

        // Single read, ack two cycles after the strobe.
        set_req(0, 1'b0, 1, 32'd0);
        run_txn(2, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0, NEVER);

        // Write with ack present every cycle.
        set_req(2, 1'b1, 0, 32'h1234_5678);
        run_txn(0, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, NEVER);

        // All requesters hold requests; rotation and 3-cycle spacing.
        for (int i = 0; i < NRQ; i++) new_req(i);
        for (int n = 0; n < 5; n++) run_txn(0, $urandom, 1'b0, 1'b1, 1'b0, NEVER);
        for (int i = 0; i < NRQ; i++) rv[i] = 1'b0;

        // Timeout with late acks, then a normal access.
        set_req(1, 1'b0, 2, 32'd0);
        run_txn(NEVER, 32'd0, 1'b1, 1'b0, 1'b0, NEVER);
        set_req(1, 1'b1, 1, 32'h5555_AAAA);
        run_txn(1, 32'h7777_0001, 1'b1, 1'b0, 1'b0, NEVER);

        // Illegal address, read and write.
        set_req(0, 1'b0, 3, 32'd0);
        run_txn(0, $urandom, 1'b1, 1'b0, 1'b0, NEVER);
        set_req(3, 1'b1, 3, 32'hCAFE_0003);
        run_txn(0, $urandom, 1'b1, 1'b0, 1'b0, NEVER);

        // Random traffic.
        for (int n = 0; n < 250; n++)
            run_txn($urandom_range(0, TO + 2), $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b1, NEVER);
        for (int i = 0; i < NRQ; i++) rv[i] = 1'b0;
        for (int n = 0; n < 8; n++) run_txn(0, 32'd0, 1'b0, 1'b0, 1'b0, NEVER);

        // Reset in WAIT: pointer returns to 0 and the aborted access never responds.
        set_req(1, 1'b0, 0, 32'd0);
        run_txn(0, 32'h1111_2222, 1'b0, 1'b0, 1'b0, NEVER);
        set_req(3, 1'b0, 0, 32'd0);
        run_txn(NEVER, 32'd0, 1'b0, 1'b0, 1'b0, 2);
        for (int i = 0; i < NRQ; i++) rv[i] = 1'b0;
        drive_reqs();
        rst          = 1'b1;
        bus.bank_ack = 1'b0;
        @(negedge clk);
        check_eq("wait_RdCE", 32'(bus.RdCE), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_all_zero();
        @(posedge clk); #1;
        rr = 0;
        for (int n = 0; n < 6; n++) run_txn(0, 32'd0, 1'b0, 1'b0, 1'b0, NEVER);
        set_req(0, 1'b0, 1, 32'd0);
        set_req(3, 1'b0, 2, 32'd0);
        run_txn(1, 32'h3333_4444, 1'b0, 1'b0, 1'b0, NEVER);
        run_txn(0, 32'h5555_6666, 1'b0, 1'b0, 1'b0, NEVER);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ipif_access_arbiter.md
# ipif_access_arbiter

Round-robin arbiter that shares one IPIF register-bank access port in the IP clock domain among `N_REQ` internal requesters, such as sequencers, calibration engines or a debug master. It turns each granted request into a single-cycle `RdCE`/`WrCE` strobe with write data. It then waits for the bank's acknowledge, or times out, and returns read data and status to the requester that was granted. It sits between the IP-side consumers and the parameter register bank that the bus-to-IP clock converter feeds.

## Interface
- `N_REQ`, default 4: number of requesters, from 2 to 16.
- `N_REG`, default 2: number of registers in the bank; `AW = max(1, $clog2(N_REG))`.
- `C_S_AXI_DATA_WIDTH`, default 32: register data width `DW`.
- `TIMEOUT`, default 255: number of WAIT cycles before an access is aborted; range 1 to 65535.
- `IP_clk` in 1: the single clock; all logic is on its rising edge.
- `IP_rst` in 1: synchronous, active-high reset.
- `req_valid` in `N_REQ`: per-requester request. Once raised, it must be held together with its fields until `req_ready`.
- `req_write` in `N_REQ`: 1 = write, 0 = read.
- `req_addr` in `N_REQ*AW`: register index, packed with requester `i` at `[i*AW +: AW]`.
- `req_wdata` in `N_REQ*DW`: write data, packed with requester `i` at `[i*DW +: DW]`.
- `req_ready` out `N_REQ`: one-cycle pulse to the granted requester in the ISSUE cycle; the request is consumed.
- `rsp_valid` out `N_REQ`: one-cycle pulse to the granted requester in the RESP cycle.
- `rsp_rdata` out `DW`: read data; meaningful only while `rsp_valid` is high.
- `rsp_err` out 1: access timed out or had an illegal address; meaningful only while `rsp_valid` is high.
- `RdCE` out `N_REG`: one-hot read strobe to the bank.
- `WrCE` out `N_REG`: one-hot write strobe to the bank.
- `bank_wdata` out `DW`: write data, valid while `WrCE` is nonzero.
- `bank_rdata` in `DW`: read data, sampled on the cycle `bank_ack` is high.
- `bank_ack` in 1: bank completion, one cycle high.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - If any `req_valid` is high, register the winner as `grant` and go to ISSUE.
  - The winner is the first requester with `req_valid` high, searching upward from `rr_ptr` modulo `N_REQ`.
  - Also latch that requester's write flag, address and data.
- ISSUE
  - Pulse `req_ready[grant]`.
  - Legal address (`addr < N_REG`):
    - Assert `RdCE[addr]` or `WrCE[addr]` for exactly this cycle; `bank_wdata` = latched data on writes.
    - If `bank_ack` is high this same cycle, capture `bank_rdata` and go to RESP; otherwise go to WAIT.
  - Illegal address: assert no strobe, set the error flag, and go to RESP.
- WAIT
  - On `bank_ack`: capture `bank_rdata` (captured on writes too) and go to RESP with error = 0.
  - If `timeout_cnt` reaches `TIMEOUT` first: go to RESP with error = 1 and captured data = 0.
  - `timeout_cnt` clears on entry to WAIT and increments by 1 each WAIT cycle. It is 16 bits and saturates; it never wraps.
- RESP
  - Drive `rsp_valid[grant]` = 1, `rsp_rdata` = captured data, `rsp_err` = error flag.
  - Set `rr_ptr` = (`grant` + 1) mod `N_REQ`, then go to IDLE.
- A `bank_ack` seen in IDLE, RESP, or in WAIT after a timeout has fired is ignored.
- Requests that change or drop before `req_ready` give undefined results; no protocol check is done.
- Writes and reads are treated identically for arbitration and fairness.

## Timing
- Reset values:
  - State = IDLE, `rr_ptr` = 0, `grant` = 0, `timeout_cnt` = 0.
  - `req_ready`, `rsp_valid`, `RdCE`, `WrCE` all 0.
  - `rsp_rdata`, `rsp_err`, `bank_wdata` all 0.
- All outputs are registered or decoded only from registered state; there is no combinational path from `req_*` to any output.
- Latency, counting `req_valid` sampled in IDLE as cycle 0:
  - Strobe and `req_ready` appear in cycle 1.
  - With `bank_ack` in cycle 1, `rsp_valid` appears in cycle 2.
  - With `bank_ack` in cycle 1+k, `rsp_valid` appears in cycle 2+k.
  - A timed-out access gives `rsp_valid` in cycle `2+TIMEOUT`.
- Back-to-back throughput: one access every 3 cycles at minimum. IDLE is always visited, so a new grant is sampled in the cycle after RESP.
- `IP_rst` in any state:
  - Next state is IDLE and all strobes and pulses go to 0 the next cycle.
  - An in-flight access gets no response; the requester must reissue.
- Simultaneous requests from all `N_REQ` requesters: each is served exactly once in rotation starting at `rr_ptr`, and no requester is served twice before every other pending requester is served once.

## Test plan
- **Single read.** After reset, requester 0 reads addr 1 and the bank acks 2 cycles after `RdCE[1]` with `0xA5A5_0001`.
  - `RdCE` = 2'b10 for 1 cycle.
  - `rsp_valid[0]` comes 3 cycles after `RdCE`, with rdata = `0xA5A5_0001` and err = 0.
- **Same-cycle ack.** Requester 2 writes `0x1234_5678` to addr 0 and `bank_ack` is tied high.
  - `WrCE` = 2'b01 and `bank_wdata` = `0x1234_5678` in cycle 1.
  - `rsp_valid[2]` in cycle 2.
- **Fairness.** All 4 requesters hold `req_valid` continuously and the bank acks immediately.
  - Grant order is 0, 1, 2, 3, 0, one grant every 3 cycles.
  - No `req_ready` overlaps another.
- **Timeout.** `TIMEOUT` = 4 and the bank never acks.
  - `rsp_valid` arrives 6 cycles after `req_valid` is sampled, with err = 1 and rdata = 0.
  - A late `bank_ack` after that is ignored, and the next access proceeds normally.
- **Illegal address.** `N_REG` = 3 and a read is issued to addr 3.
  - No `RdCE` or `WrCE` is asserted.
  - `rsp_valid` comes in cycle 2 with err = 1.
- **Reset mid-access.** `IP_rst` is asserted in WAIT.
  - All outputs are 0 the next cycle and no `rsp_valid` is produced.
  - After release, the pending requester 0 is granted first because `rr_ptr` = 0.
